// File: rtl/data_memory_ls_pkg.sv
// Shared core definitions: RV32I load/store funct3 codes and the
// data-memory clear-sequencer state encoding.
package data_memory_ls_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with four byte-lane write enables, one synchronous
// write port and one asynchronous read port.
module dmem_byte_ram #(
  parameter int WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] r_mem [WORDS];

  // NOTE: the array has no reset so it maps onto plain RAM; contents are
  // zeroed by the clear sequencer in the parent instead.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/data_memory_ls.sv
// Byte-addressable RV32I data memory: load/store sizing, extension,
// alignment/range checks and a word-by-word clear sequencer.
module data_memory_ls
  import data_memory_ls_pkg::*;
#(
  parameter int DEPTH_BYTES   = 1024,
  parameter int ADDR_W        = 32,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              clear_req,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              misaligned,
  output logic              fault
);

  localparam int WORDS   = DEPTH_BYTES / 4;
  localparam int BYTE_AW = $clog2(DEPTH_BYTES);
  localparam int IDX_W   = BYTE_AW - 2;

  state_t           r_state, w_next_state;
  logic [IDX_W-1:0] r_clr_idx, w_next_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_next_state;
      r_clr_idx <= w_next_idx;
    end
  end

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_clr_idx;
    case (r_state)
      ST_CLEAR: begin
        w_next_idx = r_clr_idx + IDX_W'(1);
        if (r_clr_idx == IDX_W'(WORDS - 1)) w_next_state = ST_READY;
      end
      ST_READY: begin
        if (clear_req) begin
          w_next_state = ST_CLEAR;
          w_next_idx   = '0;
        end
      end
      default: w_next_state = ST_CLEAR;
    endcase
  end

  logic w_access, w_is_half, w_is_word, w_illegal_f3, w_out_of_range;

  assign busy           = (r_state == ST_CLEAR);
  assign w_access       = mem_read | mem_write;
  assign w_is_half      = (funct3 == F3_H) | (funct3 == F3_HU);
  assign w_is_word      = (funct3 == F3_W);
  assign w_out_of_range = (addr >= ADDR_W'(DEPTH_BYTES));
  assign w_illegal_f3   = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                        | (mem_write & ((funct3 == F3_BU) | (funct3 == F3_HU)));

  assign misaligned = w_access & ((w_is_half & addr[0]) |
                                  (w_is_word & (addr[1:0] != 2'b00)));
  assign fault      = w_access & (w_out_of_range | w_illegal_f3 | busy);

  // Physical lane/half of the addressed byte; legacy order mirrors the lanes.
  logic [IDX_W-1:0] w_word_idx;
  logic [1:0]       w_lane;
  logic             w_hsel;

  assign w_word_idx = addr[BYTE_AW-1:2];
  assign w_lane     = LITTLE_ENDIAN ? addr[1:0] : ~addr[1:0];
  assign w_hsel     = LITTLE_ENDIAN ? addr[1] : ~addr[1];

  logic [3:0]  w_st_be;
  logic [31:0] w_st_data;
  logic        w_store_ok;

  always_comb begin
    w_st_be   = 4'b0000;
    w_st_data = wdata;
    case (funct3)
      F3_B: begin
        w_st_be   = 4'b0001 << w_lane;
        w_st_data = {4{wdata[7:0]}};
      end
      F3_H: begin
        w_st_be   = w_hsel ? 4'b1100 : 4'b0011;
        w_st_data = {2{wdata[15:0]}};
      end
      F3_W:    w_st_be = 4'b1111;
      default: w_st_be = 4'b0000;
    endcase
  end

  assign w_store_ok = mem_write & ~busy & ~fault & ~misaligned & ~clear_req;

  logic [3:0]       w_ram_we;
  logic [IDX_W-1:0] w_ram_waddr;
  logic [31:0]      w_ram_wdata;
  logic [31:0]      w_rd_word;

  assign w_ram_we    = busy ? 4'b1111 : (w_store_ok ? w_st_be : 4'b0000);
  assign w_ram_waddr = busy ? r_clr_idx : w_word_idx;
  assign w_ram_wdata = busy ? 32'h0 : w_st_data;

  dmem_byte_ram #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_ram_waddr),
    .wdata (w_ram_wdata),
    .raddr (w_word_idx),
    .rdata (w_rd_word)
  );

  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;

  assign w_rd_byte = w_rd_word[{w_lane, 3'b000} +: 8];
  assign w_rd_half = w_hsel ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    rdata = 32'h0;
    if (mem_read & ~busy & ~fault & ~misaligned) begin
      case (funct3)
        F3_B:    rdata = {{24{w_rd_byte[7]}}, w_rd_byte};
        F3_BU:   rdata = {24'h0, w_rd_byte};
        F3_H:    rdata = {{16{w_rd_half[15]}}, w_rd_half};
        F3_HU:   rdata = {16'h0, w_rd_half};
        F3_W:    rdata = w_rd_word;
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed bench for data_memory_ls: a little-endian and a legacy-order
// instance share stimulus; expectations go through a scoreboard queue.
module tb_data_memory_ls;
  import data_memory_ls_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write, mem_read, clear_req;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata_be;
  logic        busy, misaligned, fault;
  logic        busy_be, misaligned_be, fault_be;

  always #5 clk = ~clk;

  data_memory_ls #(.DEPTH_BYTES(1024), .ADDR_W(32), .LITTLE_ENDIAN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .funct3(funct3), .addr(addr), .wdata(wdata), .clear_req(clear_req),
    .rdata(rdata), .busy(busy), .misaligned(misaligned), .fault(fault)
  );

  data_memory_ls #(.DEPTH_BYTES(1024), .ADDR_W(32), .LITTLE_ENDIAN(1'b0)) u_dut_be (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .funct3(funct3), .addr(addr), .wdata(wdata), .clear_req(clear_req),
    .rdata(rdata_be), .busy(busy_be), .misaligned(misaligned_be), .fault(fault_be)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] observed);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed=%08h expected=none", observed);
      return;
    end
    e = sb.pop_front();
    assert (observed === e.val)
    else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", e.tag, observed, e.val);
    end
  endtask

  task automatic drive(input logic mw, input logic mr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic cr);
    @(negedge clk);
    mem_write = mw;
    mem_read  = mr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    clear_req = cr;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a);
    drive(1'b0, 1'b1, f3, a, 32'h0, 1'b0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    drive(1'b1, 1'b0, f3, a, wd, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    clear_req = 1'b0;
    funct3    = F3_W;
    addr      = 32'h0;
    wdata     = 32'h0;

    // Reset held low for three cycles; a load during reset is blocked.
    load(F3_W, 32'h0);
    push("rst_busy", 32'h1);
    push("rst_rdata", 32'h0);
    push("rst_fault", 32'h1);
    check({31'b0, busy});
    check(rdata);
    check({31'b0, fault});
    idle();
    push("rst_fault_idle", 32'h0);
    check({31'b0, fault});
    @(negedge clk);
    reset = 1'b1;

    // Sweep length after release, with a store attempted mid-sweep to word 0.
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 10) begin
        mem_write = 1'b1; funct3 = F3_W; addr = 32'h0; wdata = 32'hDEADBEEF;
        #1;
        push("sweep_store_fault", 32'h1);
        check({31'b0, fault});
      end
      if (n == 11) mem_write = 1'b0;
    end
    push("busy_len_after_reset", 32'd256);
    check(n);
    push("busy_be_done", 32'h0);
    check({31'b0, busy_be});

    load(F3_W, 32'h3FC);
    push("lw_3fc_cleared", 32'h0);
    push("lw_3fc_no_fault", 32'h0);
    check(rdata);
    check({31'b0, fault});
    load(F3_W, 32'h0);
    push("lw_0_sweep_store_dropped", 32'h0);
    check(rdata);

    // Sign/zero extension; legacy-order instance sees mirrored lanes.
    store(F3_W, 32'h10, 32'h80FF7F01);
    load(F3_B, 32'h10);
    push("lb_10", 32'h00000001);
    push("be_lb_10", 32'hFFFFFF80);
    check(rdata);
    check(rdata_be);
    load(F3_B, 32'h11);
    push("lb_11", 32'h0000007F);
    check(rdata);
    load(F3_B, 32'h12);
    push("lb_12", 32'hFFFFFFFF);
    check(rdata);
    load(F3_BU, 32'h13);
    push("lbu_13", 32'h00000080);
    push("be_lbu_13", 32'h00000001);
    check(rdata);
    check(rdata_be);
    load(F3_H, 32'h12);
    push("lh_12", 32'hFFFF80FF);
    push("be_lh_12", 32'h00007F01);
    check(rdata);
    check(rdata_be);
    load(F3_HU, 32'h12);
    push("lhu_12", 32'h000080FF);
    check(rdata);

    // Byte and half stores merge into an existing word.
    store(F3_W, 32'h20, 32'h11223344);
    store(F3_B, 32'h21, 32'h000000AA);
    store(F3_H, 32'h22, 32'h0000BEEF);
    load(F3_W, 32'h20);
    push("lw_20_merged", 32'hBEEFAA44);
    push("be_lw_20_merged", 32'h11AABEEF);
    check(rdata);
    check(rdata_be);

    // Misalignment, range and illegal-code checks.
    store(F3_H, 32'h21, 32'h00005555);
    push("sh_21_misaligned", 32'h1);
    check({31'b0, misaligned});
    load(F3_W, 32'h20);
    push("lw_20_unchanged", 32'hBEEFAA44);
    check(rdata);
    load(F3_W, 32'h22);
    push("lw_22_misaligned", 32'h1);
    push("lw_22_rdata", 32'h0);
    check({31'b0, misaligned});
    check(rdata);
    load(F3_W, 32'h400);
    push("lw_400_fault", 32'h1);
    check({31'b0, fault});
    load(3'b011, 32'h0);
    push("f3_011_fault", 32'h1);
    check({31'b0, fault});
    store(F3_BU, 32'h20, 32'h00000000);
    push("sbu_fault", 32'h1);
    check({31'b0, fault});
    load(F3_W, 32'h20);
    push("lw_20_after_faults", 32'hBEEFAA44);
    check(rdata);

    // clear_req beats a same-cycle store; a second request mid-sweep is ignored.
    store(F3_W, 32'h3FC, 32'h5555AAAA);
    load(F3_W, 32'h3FC);
    push("lw_3fc_written", 32'h5555AAAA);
    check(rdata);
    drive(1'b1, 1'b0, F3_W, 32'h0, 32'h12345678, 1'b1);
    push("busy_before_clear_edge", 32'h0);
    check({31'b0, busy});
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 50) clear_req = 1'b1;
      if (n == 51) clear_req = 1'b0;
    end
    push("busy_len_clear_req", 32'd256);
    check(n);
    load(F3_W, 32'h0);
    push("lw_0_after_clear", 32'h0);
    check(rdata);
    load(F3_W, 32'h3FC);
    push("lw_3fc_after_clear", 32'h0);
    check(rdata);

    // Reset during a sweep restarts it from word 0.
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    push("busy_in_midsweep_reset", 32'h1);
    check({31'b0, busy});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
    end
    push("busy_len_after_midsweep_reset", 32'd256);
    check(n);

    // Simultaneous read and write: read sees old contents, write commits.
    drive(1'b1, 1'b1, F3_W, 32'h8, 32'hCAFEF00D, 1'b0);
    push("rw_same_cycle", 32'h0);
    check(rdata);
    load(F3_W, 32'h8);
    push("rw_next_cycle", 32'hCAFEF00D);
    check(rdata);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
